// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies page P00..PFF
// of CPU memory into OAM as 256 consecutive OAMDATA writes.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          MEM_LAT      = 1,
  parameter int          HALT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_WE,
  output logic [7:0]  ppu_data,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_READ, S_WAIT, S_WRITE, S_RELEASE, S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_page, r_idx, r_ppu_data;
  logic [15:0] r_cnt;
  logic        w_trig, w_halt_last, w_wait_last;

  assign w_trig      = cpu_WE && (cpu_addr == DMA_REG_ADDR);
  assign w_halt_last = (r_cnt == 16'(HALT_CYCLES - 1));
  assign w_wait_last = (r_cnt == 16'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_trig)      w_state_next = S_HALT;
      S_HALT:    if (w_halt_last) w_state_next = S_READ;
      S_READ:                     w_state_next = S_WAIT;
      S_WAIT:    if (w_wait_last) w_state_next = S_WRITE;
      S_WRITE:                    w_state_next = S_RELEASE;
      S_RELEASE: w_state_next = (r_idx == 8'hFF) ? S_DONE : S_READ;
      S_DONE:                     w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // r_cnt restarts on every state change and times the HALT and WAIT dwell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_page     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ppu_data <= '0;
    end else begin
      r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + 16'd1;
      if (r_state == S_IDLE && w_trig) begin
        r_page <= cpu_data_in;
        r_idx  <= '0;
      end
      if (r_state == S_WAIT && w_wait_last) r_ppu_data <= mem_rdata;
      if (r_state == S_RELEASE && r_idx != 8'hFF) r_idx <= r_idx + 8'd1;
    end
  end

  always_comb begin
    cpu_halt     = 1'b0;
    mem_rd       = 1'b0;
    ppu_cs_n     = 1'b1;
    ppu_reg_addr = 3'd0;
    ppu_WE       = 1'b0;
    case (r_state)
      S_HALT, S_WAIT: cpu_halt = 1'b1;
      S_READ: begin
        cpu_halt = 1'b1;
        mem_rd   = 1'b1;
      end
      S_WRITE: begin
        cpu_halt     = 1'b1;
        ppu_cs_n     = 1'b0;
        ppu_reg_addr = 3'd4;
        ppu_WE       = 1'b1;
      end
      S_RELEASE: begin
        cpu_halt     = 1'b1;
        ppu_reg_addr = 3'd4;
      end
      default: ;
    endcase
  end

  // idx never carries into the page, so reads stay inside page P.
  assign mem_addr   = {r_page, r_idx};
  assign ppu_data   = r_ppu_data;
  assign dma_active = cpu_halt;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: two instances (MEM_LAT=1 and MEM_LAT=3) share the CPU bus;
// expected read addresses and OAMDATA bytes are queued per transfer and popped per pulse.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_WE;

  logic        halt_w   [2];
  logic [15:0] maddr_w  [2];
  logic        mrd_w    [2];
  logic [7:0]  rdata_w  [2];
  logic        cs_w     [2];
  logic [2:0]  ra_w     [2];
  logic        we_w     [2];
  logic [7:0]  pd_w     [2];
  logic        act_w    [2];

  logic [7:0]  mem [65536];
  logic [15:0] q_addr [2][$];
  logic [7:0]  q_data [2][$];
  int          halt_cnt [2];
  int          rd_cnt   [2];
  int          we_cnt   [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [7:0] sd [LAT];
    logic       sv [LAT];
    logic       prev_cs;

    oam_dma #(.DMA_REG_ADDR(16'h4014), .MEM_LAT(LAT), .HALT_CYCLES(1)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_addr     (cpu_addr),
      .cpu_data_in  (cpu_data_in),
      .cpu_WE       (cpu_WE),
      .cpu_halt     (halt_w[gi]),
      .mem_addr     (maddr_w[gi]),
      .mem_rd       (mrd_w[gi]),
      .mem_rdata    (rdata_w[gi]),
      .ppu_cs_n     (cs_w[gi]),
      .ppu_reg_addr (ra_w[gi]),
      .ppu_WE       (we_w[gi]),
      .ppu_data     (pd_w[gi]),
      .dma_active   (act_w[gi])
    );

    // Memory model: data is valid only LAT cycles after mem_rd, 8'hEE otherwise.
    always @(posedge clk) begin
      sv[0] <= mrd_w[gi];
      sd[0] <= mem[maddr_w[gi]];
      for (int k = 1; k < LAT; k++) begin
        sv[k] <= sv[k-1];
        sd[k] <= sd[k-1];
      end
    end
    assign rdata_w[gi] = sv[LAT-1] ? sd[LAT-1] : 8'hEE;

    always @(negedge clk) begin
      if (!reset_n) begin
        prev_cs = 1'b1;
      end else begin
        if (halt_w[gi]) halt_cnt[gi]++;
        if (mrd_w[gi]) begin
          rd_cnt[gi]++;
          check($sformatf("rd_expected%0d", gi), 32'(q_addr[gi].size() > 0), 32'd1);
          if (q_addr[gi].size() > 0)
            check($sformatf("mem_addr%0d", gi), 32'(maddr_w[gi]), 32'(q_addr[gi].pop_front()));
        end
        if (!cs_w[gi]) begin
          we_cnt[gi]++;
          check($sformatf("cs_high_before%0d", gi), 32'(prev_cs), 32'd1);
          check($sformatf("ppu_we%0d", gi), 32'(we_w[gi]), 32'd1);
          check($sformatf("ppu_reg_addr%0d", gi), 32'(ra_w[gi]), 32'd4);
          check($sformatf("wr_expected%0d", gi), 32'(q_data[gi].size() > 0), 32'd1);
          if (q_data[gi].size() > 0)
            check($sformatf("ppu_data%0d", gi), 32'(pd_w[gi]), 32'(q_data[gi].pop_front()));
        end
        prev_cs = cs_w[gi];
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      halt_cnt[k] = 0;
      rd_cnt[k]   = 0;
      we_cnt[k]   = 0;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    tick(1);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_WE      = 1'b1;
    tick(1);
    cpu_WE      = 1'b0;
    $display("[TB] cpu write %04h <= %02h", a, d);
  endtask

  task automatic push_expected(input logic [7:0] page);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) begin
        q_addr[k].push_back({page, 8'(i)});
        q_data[k].push_back(mem_val({page, 8'(i)}));
      end
  endtask

  task automatic finish_run(input string tag);
    int cyc;
    cyc = 0;
    while ((halt_w[0] || halt_w[1] || q_data[0].size() > 0 || q_data[1].size() > 0) && cyc < 4000) begin
      tick(1);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 4000), 32'd1);
    tick(3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_halt_cycles%0d", tag, k), 32'(halt_cnt[k]), 32'(1 + 256 * (3 + (k == 0 ? 1 : 3))));
      check($sformatf("%s_rd_pulses%0d", tag, k), 32'(rd_cnt[k]), 32'd256);
      check($sformatf("%s_we_pulses%0d", tag, k), 32'(we_cnt[k]), 32'd256);
      check($sformatf("%s_left%0d", tag, k), 32'(q_addr[k].size() + q_data[k].size()), 32'd0);
      check($sformatf("%s_idle_halt%0d", tag, k), 32'(halt_w[k]), 32'd0);
      check($sformatf("%s_idle_act%0d", tag, k), 32'(act_w[k]), 32'd0);
    end
    $display("[TB] transfer %s: halt %0d/%0d cycles, writes %0d/%0d", tag,
             halt_cnt[0], halt_cnt[1], we_cnt[0], we_cnt[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_halt%0d", tag, k), 32'(halt_w[k]), 32'd0);
      check($sformatf("%s_mem_rd%0d", tag, k), 32'(mrd_w[k]), 32'd0);
      check($sformatf("%s_cs_n%0d", tag, k), 32'(cs_w[k]), 32'd1);
      check($sformatf("%s_ppu_we%0d", tag, k), 32'(we_w[k]), 32'd0);
      check($sformatf("%s_reg_addr%0d", tag, k), 32'(ra_w[k]), 32'd0);
      check($sformatf("%s_ppu_data%0d", tag, k), 32'(pd_w[k]), 32'd0);
      check($sformatf("%s_mem_addr%0d", tag, k), 32'(maddr_w[k]), 32'd0);
      check($sformatf("%s_active%0d", tag, k), 32'(act_w[k]), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < 65536; a++) mem[a] = mem_val(16'(a));
    reset_n     = 1'b0;
    cpu_addr    = '0;
    cpu_data_in = '0;
    cpu_WE      = 1'b0;
    clear_counts();
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(2);

    // Writes to neighbouring registers must not start a transfer.
    clear_counts();
    cpu_write(16'h4015, 8'h02);
    cpu_write(16'h4013, 8'h02);
    tick(10);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("no_trig_halt_cycles%0d", k), 32'(halt_cnt[k]), 32'd0);
      check($sformatf("no_trig_rd%0d", k), 32'(rd_cnt[k]), 32'd0);
    end

    // Page 0x02 clean transfer.
    clear_counts();
    push_expected(8'h02);
    cpu_write(16'h4014, 8'h02);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("halt_after_trig%0d", k), 32'(halt_w[k]), 32'd1);
      check($sformatf("act_after_trig%0d", k), 32'(act_w[k]), 32'd1);
    end
    finish_run("page02");

    // Page 0xFF must stay in FF00..FFFF.
    clear_counts();
    push_expected(8'hFF);
    cpu_write(16'h4014, 8'hFF);
    finish_run("pageFF");

    // Retrigger with page 0x03 mid-transfer is ignored.
    clear_counts();
    push_expected(8'h02);
    cpu_write(16'h4014, 8'h02);
    cyc = 0;
    while (!(mrd_w[0] && maddr_w[0] == 16'h0240) && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    check("retrig_reach_idx40", 32'(cyc < 2000), 32'd1);
    cpu_write(16'h4014, 8'h03);
    finish_run("retrig");

    // Reset during the WRITE of idx 0x80 aborts immediately.
    clear_counts();
    push_expected(8'h02);
    cpu_write(16'h4014, 8'h02);
    cyc = 0;
    while (!(!cs_w[0] && we_cnt[0] == 128) && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    check("abort_reach_idx80", 32'(cyc < 2000), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int k = 0; k < 2; k++) begin
      q_addr[k].delete();
      q_data[k].delete();
    end
    tick(2);
    reset_n = 1'b1;
    tick(4);
    for (int k = 0; k < 2; k++)
      check($sformatf("abort_idle_halt%0d", k), 32'(halt_w[k]), 32'd0);
    $display("[TB] transfer aborted by reset at idx 80");

    // A fresh trigger after the abort runs to completion.
    clear_counts();
    push_expected(8'h02);
    cpu_write(16'h4014, 8'h02);
    finish_run("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
